// File: rtl/lstm_fx_pkg.sv
// Fixed-point helpers shared by the LSTM element-wise back end: Q-format constants and DW saturation.
package lstm_fx_pkg;

  localparam int FX_FRAC_SZ = 10;

  function automatic int fx_one(input int frac);
    return 1 << frac;
  endfunction

  function automatic int fx_half(input int frac);
    return 1 << (frac - 1);
  endfunction

  function automatic int fx_2p5(input int frac);
    return (5 << frac) >> 1;
  endfunction

  function automatic int fx_0p375(input int frac);
    return (3 << frac) >> 3;
  endfunction

  localparam int FX_ONE   = fx_one(FX_FRAC_SZ);
  localparam int FX_HALF  = fx_half(FX_FRAC_SZ);
  localparam int FX_2P5   = fx_2p5(FX_FRAC_SZ);
  localparam int FX_0P375 = fx_0p375(FX_FRAC_SZ);

  // Clamp a sign-extended wide value into the signed range of a dw-bit word.
  function automatic logic signed [63:0] sat_dw(input logic signed [63:0] x, input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// Team synchronous FIFO: registered read data (valid the cycle after rd_en), ignores push-when-full/pop-when-empty.
module fifo_sync #(
  parameter int FIFO_WIDTH = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [FIFO_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic                  do_wr;
  logic                  do_rd;

  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rd_data <= mem[rd_ptr];
      end
      count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end

endmodule

// File: rtl/lstm_tanh_pwl.sv
// One-lane piecewise-linear tanh: |x|<0.5 -> |x|, <2.5 -> |x|/4+0.375, else 1.0, sign restored.
module lstm_tanh_pwl
  import lstm_fx_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_SZ    = 10
) (
  input  logic signed [DATA_WIDTH-1:0] x,
  output logic signed [DATA_WIDTH-1:0] y
);
  localparam int XW = DATA_WIDTH + 1;
  localparam logic [XW-1:0] HALF = XW'(fx_half(FRAC_SZ));
  localparam logic [XW-1:0] BRK2 = XW'(fx_2p5(FRAC_SZ));
  localparam logic [XW-1:0] OFS  = XW'(fx_0p375(FRAC_SZ));
  localparam logic [XW-1:0] ONE  = XW'(fx_one(FRAC_SZ));

  logic [XW-1:0] ax;
  logic [XW-1:0] mag;

  // One extra bit keeps |most-negative| representable.
  always_comb begin
    ax = x[DATA_WIDTH-1] ? -{x[DATA_WIDTH-1], x} : {1'b0, x};
    if (ax < HALF)      mag = ax;
    else if (ax < BRK2) mag = (ax >> 2) + OFS;
    else                mag = ONE;
    y = x[DATA_WIDTH-1] ? DATA_WIDTH'(-mag) : DATA_WIDTH'(mag);
  end

endmodule

// File: rtl/lstm_cell_ew_lanes.sv
// LSTM element-wise back end: c_t = i*g + f*c_prev, h_t = o*tanh(c_t) on LANES lanes per beat.
// Optional LSTM_CELL_CLIP_EN clamps c_t to +/-CELL_CLIP after saturation.
module lstm_cell_ew_lanes
  import lstm_fx_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_SZ    = 10,
  parameter int LANES      = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int ELEMENTS   = 32,
  parameter int CELL_CLIP  = 4096
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_wr_en,
  input  logic                        g_wr_en,
  input  logic                        f_wr_en,
  input  logic                        o_wr_en,
  input  logic [LANES*DATA_WIDTH-1:0] i_data,
  input  logic [LANES*DATA_WIDTH-1:0] g_data,
  input  logic [LANES*DATA_WIDTH-1:0] f_data,
  input  logic [LANES*DATA_WIDTH-1:0] o_data,
  output logic                        i_full,
  output logic                        g_full,
  output logic                        f_full,
  output logic                        o_full,
  input  logic                        cprev_empty,
  output logic                        cprev_rd_en,
  input  logic [LANES*DATA_WIDTH-1:0] cprev_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*DATA_WIDTH-1:0] c_out,
  output logic [LANES*DATA_WIDTH-1:0] h_out,
  output logic                        cell_done
);
  localparam int W  = LANES * DATA_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int CW = (ELEMENTS > 1) ? $clog2(ELEMENTS) : 1;
  localparam logic [CW-1:0] LAST = CW'(ELEMENTS - 1);
`ifdef LSTM_CELL_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif
  localparam logic signed [DW-1:0] CLIP_P = DW'(CELL_CLIP);
  localparam logic signed [DW-1:0] CLIP_N = DW'(-CELL_CLIP);

  logic [W-1:0] i_q, g_q, f_q, o_q;
  logic i_empty, g_empty, f_empty, o_empty;
  logic advance, fire;
  logic v0, v1, v2;
  logic [CW-1:0] elem_cnt;

  assign advance     = !(out_valid && !out_ready);
  assign fire        = !i_empty && !g_empty && !f_empty && !o_empty && !cprev_empty && advance;
  assign cprev_rd_en = fire;

  fifo_sync #(.FIFO_WIDTH(W), .FIFO_DEPTH(FIFO_DEPTH)) u_i_fifo (
    .clk(clk), .rst(rst), .wr_en(i_wr_en), .wr_data(i_data), .rd_en(fire),
    .rd_data(i_q), .full(i_full), .empty(i_empty));
  fifo_sync #(.FIFO_WIDTH(W), .FIFO_DEPTH(FIFO_DEPTH)) u_g_fifo (
    .clk(clk), .rst(rst), .wr_en(g_wr_en), .wr_data(g_data), .rd_en(fire),
    .rd_data(g_q), .full(g_full), .empty(g_empty));
  fifo_sync #(.FIFO_WIDTH(W), .FIFO_DEPTH(FIFO_DEPTH)) u_f_fifo (
    .clk(clk), .rst(rst), .wr_en(f_wr_en), .wr_data(f_data), .rd_en(fire),
    .rd_data(f_q), .full(f_full), .empty(f_empty));
  fifo_sync #(.FIFO_WIDTH(W), .FIFO_DEPTH(FIFO_DEPTH)) u_o_fifo (
    .clk(clk), .rst(rst), .wr_en(o_wr_en), .wr_data(o_data), .rd_en(fire),
    .rd_data(o_q), .full(o_full), .empty(o_empty));

  // v0 marks FIFO read data valid; the whole chain freezes with advance low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0        <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      elem_cnt  <= '0;
      cell_done <= 1'b0;
    end else begin
      cell_done <= 1'b0;
      if (advance) begin
        v0        <= fire;
        v1        <= v0;
        v2        <= v1;
        out_valid <= v2;
      end
      if (out_valid && out_ready) begin
        if (elem_cnt == LAST) begin
          elem_cnt  <= '0;
          cell_done <= 1'b1;
        end else begin
          elem_cnt <= elem_cnt + CW'(1);
        end
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic signed [DW-1:0]   ia, ga, fa, ca, oa;
    logic signed [2*DW-1:0] prod_ig, prod_fc, prod_ot, p1_q, p2_q;
    logic signed [2*DW:0]   sum_w;
    logic signed [DW-1:0]   o1_q, o2_q, c2_q, c_sat, c_next, t_w, h_next, c_q, h_q;

    assign ia = i_q[k*DW +: DW];
    assign ga = g_q[k*DW +: DW];
    assign fa = f_q[k*DW +: DW];
    assign oa = o_q[k*DW +: DW];
    assign ca = cprev_data[k*DW +: DW];

    assign prod_ig = (2*DW)'(ia) * (2*DW)'(ga);
    assign prod_fc = (2*DW)'(fa) * (2*DW)'(ca);
    assign sum_w   = (2*DW+1)'(p1_q) + (2*DW+1)'(p2_q);
    assign c_sat   = DW'(sat_dw(64'(sum_w), DW));

    always_comb begin
      c_next = c_sat;
      if (CLIP_EN) begin
        if (c_sat > CLIP_P)      c_next = CLIP_P;
        else if (c_sat < CLIP_N) c_next = CLIP_N;
      end
    end

    lstm_tanh_pwl #(.DATA_WIDTH(DW), .FRAC_SZ(FRAC_SZ)) u_tanh (.x(c2_q), .y(t_w));

    assign prod_ot = (2*DW)'(o2_q) * (2*DW)'(t_w);
    assign h_next  = DW'(sat_dw(64'(prod_ot >>> FRAC_SZ), DW));

    // Output registers only load real beats so a stalled or idle output keeps its last value.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        p1_q <= '0;
        p2_q <= '0;
        o1_q <= '0;
        o2_q <= '0;
        c2_q <= '0;
        c_q  <= '0;
        h_q  <= '0;
      end else if (advance) begin
        p1_q <= prod_ig >>> FRAC_SZ;
        p2_q <= prod_fc >>> FRAC_SZ;
        o1_q <= oa;
        c2_q <= c_next;
        o2_q <= o1_q;
        if (v2) begin
          c_q <= c2_q;
          h_q <= h_next;
        end
      end
    end

    assign c_out[k*DW +: DW] = c_q;
    assign h_out[k*DW +: DW] = h_q;
  end

endmodule

// File: tb/tb_lstm_cell_ew_lanes.sv
// Directed-vector bench for lstm_cell_ew_lanes (DW=16, FRAC_SZ=10, LANES=4, ELEMENTS=4).
module tb_lstm_cell_ew_lanes;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_wr_en = 1'b0, g_wr_en = 1'b0, f_wr_en = 1'b0, o_wr_en = 1'b0;
  logic [63:0] i_data = '0, g_data = '0, f_data = '0, o_data = '0;
  logic        i_full, g_full, f_full, o_full;
  logic        cprev_empty, cprev_rd_en;
  logic [63:0] cprev_data;
  logic        out_valid, cell_done;
  logic        out_ready = 1'b1;
  logic [63:0] c_out, h_out;

  int checks = 0;
  int failures = 0;

  logic [63:0] cprev_mem [256];
  int          cprev_wr = 0;
  int          cprev_rd = 0;

  always #5 clk = ~clk;

  lstm_cell_ew_lanes #(
    .DATA_WIDTH(16), .FRAC_SZ(10), .LANES(4), .FIFO_DEPTH(8), .ELEMENTS(4), .CELL_CLIP(4096)
  ) dut (
    .clk(clk), .rst(rst),
    .i_wr_en(i_wr_en), .g_wr_en(g_wr_en), .f_wr_en(f_wr_en), .o_wr_en(o_wr_en),
    .i_data(i_data), .g_data(g_data), .f_data(f_data), .o_data(o_data),
    .i_full(i_full), .g_full(g_full), .f_full(f_full), .o_full(o_full),
    .cprev_empty(cprev_empty), .cprev_rd_en(cprev_rd_en), .cprev_data(cprev_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .c_out(c_out), .h_out(h_out), .cell_done(cell_done)
  );

  // Previous-cell-state FIFO model: data appears the cycle after a pop.
  assign cprev_empty = (cprev_rd == cprev_wr);
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cprev_rd   <= cprev_wr;
      cprev_data <= '0;
    end else if (cprev_rd_en && !cprev_empty) begin
      cprev_data <= cprev_mem[cprev_rd];
      cprev_rd   <= cprev_rd + 1;
    end
  end

  function automatic logic [63:0] rep(input logic [15:0] v);
    return {4{v}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_gates(input bit pi, input bit pg, input bit pf, input bit po,
                           input logic [63:0] vi, input logic [63:0] vg,
                           input logic [63:0] vf, input logic [63:0] vo);
    i_wr_en = pi; g_wr_en = pg; f_wr_en = pf; o_wr_en = po;
    i_data = vi;  g_data = vg;  f_data = vf;  o_data = vo;
  endtask

  task automatic idle_gates();
    set_gates(0, 0, 0, 0, '0, '0, '0, '0);
  endtask

  task automatic push_cprev(input logic [63:0] v);
    cprev_mem[cprev_wr] = v;
    cprev_wr = cprev_wr + 1;
  endtask

  task automatic do_reset();
    idle_gates();
    out_ready = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    idle_gates();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (c_out !== 64'h0) begin failures++; $display("[TB] FAIL reset_c_out: got %h expected 0", c_out); end
    checks++; if (h_out !== 64'h0) begin failures++; $display("[TB] FAIL reset_h_out: got %h expected 0", h_out); end
    checks++; if (cell_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_cell_done: got %b expected 0", cell_done); end
    checks++; if ({i_full, g_full, f_full, o_full} !== 4'b0) begin failures++; $display("[TB] FAIL reset_full: got %b expected 0000", {i_full, g_full, f_full, o_full}); end
    checks++; if (cprev_rd_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_cprev_rd_en: got %b expected 0", cprev_rd_en); end
    rst = 1'b0;
    tick();
  endtask

  // 0.5*1.0 + 1.0*0.5 = 1.0; tanh_pwl(1.0) = 0.625 -> h = 640.
  task automatic test_basic();
    out_ready = 1'b1;
    push_cprev(rep(16'd512));
    set_gates(1, 1, 1, 1, rep(16'd512), rep(16'd1024), rep(16'd1024), rep(16'd1024));
    tick();
    idle_gates();
    #1;
    checks++; if (cprev_rd_en !== 1'b1) begin failures++; $display("[TB] FAIL basic_fire: got %b expected 1", cprev_rd_en); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL basic_latency_early: cycle %0d got %b expected 0", k, out_valid); end
    end
    tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL basic_latency: got %b expected 1", out_valid); end
    checks++; if (c_out !== rep(16'd1024)) begin failures++; $display("[TB] FAIL basic_c_out: got %h expected %h", c_out, rep(16'd1024)); end
    checks++; if (h_out !== rep(16'd640)) begin failures++; $display("[TB] FAIL basic_h_out: got %h expected %h", h_out, rep(16'd640)); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL basic_drain: got %b expected 0", out_valid); end
  endtask

  // Lane 0 overflows DW (saturates); lanes 1..3 give c=2.0 -> tanh_pwl = 0.875.
  task automatic test_saturation();
    logic [63:0] exp_c, exp_h;
    bit seen;
`ifdef LSTM_CELL_CLIP_EN
    exp_c = {16'd2048, 16'd2048, 16'd2048, 16'd4096};
`else
    exp_c = {16'd2048, 16'd2048, 16'd2048, 16'd32767};
`endif
    exp_h = {16'd896, 16'd896, 16'd896, 16'd1024};
    out_ready = 1'b1;
    push_cprev({16'd1024, 16'd1024, 16'd1024, 16'd32767});
    set_gates(1, 1, 1, 1, rep(16'd1024), rep(16'd1024), rep(16'd1024), rep(16'd1024));
    tick();
    idle_gates();
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      if (out_valid === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) begin failures++; $display("[TB] FAIL sat_timeout: out_valid %b expected 1", out_valid); end
    checks++; if (c_out !== exp_c) begin failures++; $display("[TB] FAIL sat_c_out: got %h expected %h", c_out, exp_c); end
    checks++; if (h_out !== exp_h) begin failures++; $display("[TB] FAIL sat_h_out: got %h expected %h", h_out, exp_h); end
    tick();
  endtask

  // Beat n: c = 0.5 + n/16, h = c/4 + 0.375.
  task automatic test_backpressure();
    int sent, got, stall;
    logic [63:0] held_c, held_h;
    do_reset();
    sent = 0; got = 0; stall = 0; held_c = '0; held_h = '0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      if (sent < 8) begin
        set_gates(1, 1, 1, 1, rep(16'd512), rep(16'd1024), rep(16'd1024), rep(16'd1024));
        push_cprev(rep(16'(64 * sent)));
        sent++;
      end else begin
        idle_gates();
      end
      if (got == 2 && stall < 5) begin
        out_ready = 1'b0;
        stall++;
      end else begin
        out_ready = 1'b1;
      end
      #1;
      if (!out_ready) begin
        if (stall == 1) begin held_c = c_out; held_h = h_out; end
        checks++;
        if (out_valid !== 1'b1 || cprev_rd_en !== 1'b0 || c_out !== held_c || h_out !== held_h) begin
          failures++;
          $display("[TB] FAIL bp_hold: valid %b rd_en %b c %h h %h required valid 1 rd_en 0 c %h h %h",
                   out_valid, cprev_rd_en, c_out, h_out, held_c, held_h);
        end
      end else if (out_valid === 1'b1) begin
        checks++;
        if (c_out !== rep(16'(512 + 64 * got)) || h_out !== rep(16'(512 + 16 * got))) begin
          failures++;
          $display("[TB] FAIL bp_beat%0d: got c %h h %h expected c %h h %h", got, c_out, h_out,
                   rep(16'(512 + 64 * got)), rep(16'(512 + 16 * got)));
        end
        got++;
      end
      tick();
    end
    idle_gates();
    out_ready = 1'b1;
    checks++; if (got != 8 || stall != 5) begin failures++; $display("[TB] FAIL bp_count: got beats %0d stalls %0d expected 8 and 5", got, stall); end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_duplicate: got out_valid %b expected 0", out_valid); end
    end
  endtask

  task automatic test_gate_skew();
    logic [15:0] exp_c [8] = '{16'd0, 16'd128, 16'd256, 16'd384, 16'd512, 16'd640, 16'd768, 16'd896};
    logic [15:0] exp_h [8] = '{16'd0, 16'd128, 16'd256, 16'd384, 16'd512, 16'd544, 16'd576, 16'd608};
    bit seen;
    int sent, got;
    do_reset();
    push_cprev(rep(16'd512));
    set_gates(1, 1, 1, 0, rep(16'd512), rep(16'd1024), rep(16'd1024), '0);
    tick();
    idle_gates();
    #1;
    for (int k = 0; k < 5; k++) begin
      checks++; if (cprev_rd_en !== 1'b0) begin failures++; $display("[TB] FAIL skew_early_fire: cycle %0d got %b expected 0", k, cprev_rd_en); end
      tick();
    end
    set_gates(0, 0, 0, 1, '0, '0, '0, rep(16'd1024));
    tick();
    idle_gates();
    #1;
    checks++; if (cprev_rd_en !== 1'b1) begin failures++; $display("[TB] FAIL skew_fire: got %b expected 1", cprev_rd_en); end
    tick();
    checks++; if (cprev_rd_en !== 1'b0) begin failures++; $display("[TB] FAIL skew_single_fire: got %b expected 0", cprev_rd_en); end
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (out_valid === 1'b1) seen = 1'b1;
      else tick();
    end
    checks++; if (!seen) begin failures++; $display("[TB] FAIL skew_timeout: out_valid %b expected 1", out_valid); end
    checks++; if (c_out !== rep(16'd1024) || h_out !== rep(16'd640)) begin failures++; $display("[TB] FAIL skew_beat: got c %h h %h expected c %h h %h", c_out, h_out, rep(16'd1024), rep(16'd640)); end
    tick();

    // Fill the i FIFO alone, then try one extra push that must be dropped.
    for (int n = 0; n < 8; n++) begin
      set_gates(1, 0, 0, 0, rep(16'(128 * n)), '0, '0, '0);
      tick();
    end
    idle_gates();
    #1;
    checks++; if (i_full !== 1'b1) begin failures++; $display("[TB] FAIL skew_i_full: got %b expected 1", i_full); end
    set_gates(1, 0, 0, 0, rep(16'd1000), '0, '0, '0);
    tick();
    idle_gates();
    #1;
    checks++; if (i_full !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("[TB] FAIL skew_full_push: full %b valid %b expected 1 0", i_full, out_valid); end
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      if (sent < 8) begin
        set_gates(0, 1, 1, 1, '0, rep(16'd1024), rep(16'd0), rep(16'd1024));
        push_cprev(rep(16'd0));
        sent++;
      end else begin
        idle_gates();
      end
      #1;
      if (out_valid === 1'b1) begin
        checks++;
        if (c_out !== rep(exp_c[got]) || h_out !== rep(exp_h[got])) begin
          failures++;
          $display("[TB] FAIL skew_fill_beat%0d: got c %h h %h expected c %h h %h", got, c_out, h_out, rep(exp_c[got]), rep(exp_h[got]));
        end
        got++;
      end
      tick();
    end
    idle_gates();
    checks++; if (got != 8) begin failures++; $display("[TB] FAIL skew_fill_count: got %0d beats expected 8", got); end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL skew_extra_beat: got out_valid %b expected 0", out_valid); end
    end
    checks++; if (i_full !== 1'b0) begin failures++; $display("[TB] FAIL skew_i_drained: got %b expected 0", i_full); end
  endtask

  // Eight beats at one per cycle: cell_done the cycle after the 4th and 8th acceptance.
  task automatic test_cell_done();
    int sent, acc, pulses, first, last;
    bit exp_done;
    do_reset();
    sent = 0; acc = 0; pulses = 0; first = -1; last = -1; exp_done = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (sent < 8) begin
        set_gates(1, 1, 1, 1, rep(16'd512), rep(16'd1024), rep(16'd1024), rep(16'd1024));
        push_cprev(rep(16'd512));
        sent++;
      end else begin
        idle_gates();
      end
      #1;
      checks++; if (cell_done !== exp_done) begin failures++; $display("[TB] FAIL done_pulse: cycle %0d got %b expected %b", cyc, cell_done, exp_done); end
      if (cell_done === 1'b1) pulses++;
      exp_done = 1'b0;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        acc++;
        if (first < 0) first = cyc;
        last = cyc;
        exp_done = (acc % 4 == 0);
      end
      tick();
    end
    idle_gates();
    checks++; if (acc != 8) begin failures++; $display("[TB] FAIL done_accepted: got %0d expected 8", acc); end
    checks++; if (pulses != 2) begin failures++; $display("[TB] FAIL done_pulses: got %0d expected 2", pulses); end
    checks++; if (last - first != 7) begin failures++; $display("[TB] FAIL back_to_back: span %0d expected 7", last - first); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    out_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      set_gates(1, 1, 1, 1, rep(16'd512), rep(16'd1024), rep(16'd1024), rep(16'd1024));
      push_cprev(rep(16'd512));
      tick();
    end
    for (int n = 0; n < 8; n++) begin
      set_gates(1, 0, 0, 0, rep(16'd256), '0, '0, '0);
      tick();
    end
    idle_gates();
    #1;
    checks++; if (out_valid !== 1'b1 || i_full !== 1'b1) begin failures++; $display("[TB] FAIL midop_setup: valid %b i_full %b expected 1 1", out_valid, i_full); end
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL midop_valid: got %b expected 0", out_valid); end
    checks++; if ({i_full, g_full, f_full, o_full} !== 4'b0) begin failures++; $display("[TB] FAIL midop_full: got %b expected 0000", {i_full, g_full, f_full, o_full}); end
    checks++; if (c_out !== 64'h0 || h_out !== 64'h0) begin failures++; $display("[TB] FAIL midop_data: got c %h h %h expected 0", c_out, h_out); end
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL midop_stale: got out_valid %b expected 0", out_valid); end
    end
    test_basic();
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_gate_skew();
    test_cell_done();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
